// File: rtl/wb_io_arbiter256.sv
// Round-robin, cyc-locked arbiter sharing one 256-bit I/O bridge port among NREQ wishbone masters,
// with a bus-timeout watchdog and steering of unsolicited IRQ-message responses.
package wb_io_arbiter256_pkg;
  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic         ack;
    logic [1:0]   err;
    logic [255:0] dat;
  } wb_cmd_response256_t;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_ERR = 2'd1;
  localparam logic [1:0] ERR_IRQ = 2'd2;
endpackage

module wb_io_arbiter256
  import wb_io_arbiter256_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 1023,
  parameter int IRQ_PORT = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  wb_cmd_request256_t  [NREQ-1:0]       s_req,
  output wb_cmd_response256_t [NREQ-1:0]       s_resp,
  output wb_cmd_request256_t                   m_req,
  input  wb_cmd_response256_t                  m_resp,
  output logic                [NREQ-1:0]       gnt_o,
  output logic                                 tmo_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            winHit;
  logic [IW-1:0]   winIdx;
  logic [IW-1:0]   candIdx;
  logic            grantCyc;
  logic            expire;

  // Rotating search beginning just after the previous winner keeps the arbitration fair.
  always_comb begin
    winHit  = 1'b0;
    winIdx  = last_q;
    candIdx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      candIdx = IW'((int'(last_q) + k) % NREQ);
      if (!winHit && s_req[candIdx].cyc) begin
        winHit = 1'b1;
        winIdx = candIdx;
      end
    end
  end

  assign grantCyc = s_req[last_q].cyc;
  // A same-cycle bridge ack or cyc drop takes precedence over the watchdog.
  assign expire   = (state_q == BUSY) && grantCyc && !m_resp.ack &&
                    (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (winHit) begin
          state_d = BUSY;
          gnt_d   = NREQ'(1) << winIdx;
          last_d  = winIdx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!grantCyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (expire) begin
          state_d = TERM;
          cnt_d   = CW'(TIMEOUT);
        end else if (m_resp.ack) begin
          cnt_d = '0;
        end else if (cnt_q < CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TERM: begin
        if (!grantCyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Bridge and master-side routing; everything is forced quiet while reset is held.
  always_comb begin
    m_req  = '0;
    s_resp = '0;
    tmo_o  = 1'b0;
    if (!rst_i) begin
      case (state_q)
        BUSY: begin
          if (expire) begin
            s_resp[last_q].ack = 1'b1;
            s_resp[last_q].err = ERR_ERR;
            tmo_o              = 1'b1;
          end else begin
            s_resp[last_q] = m_resp;
            if (grantCyc) begin
              m_req = s_req[last_q];
            end
          end
        end
        default: begin
          if (m_resp.ack && (m_resp.err == ERR_IRQ)) begin
            s_resp[IRQ_PORT] = m_resp;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: doc/wb_io_arbiter256.md
Name: wb_io_arbiter256

Overview:
- Round-robin arbiter that shares one 256-bit I/O bridge slave port between NREQ 256-bit wishbone masters, e.g. CPU cores and a DMA engine.
- Sits directly in front of the 256-to-32 I/O bridge.
- Holds a grant for a whole bus cycle (cyc-locked) and routes the bridge response back to the owning master.
- Runs a bus-timeout watchdog and steers unsolicited IRQ-message responses to a designated master.

Parameters:
- NREQ, 4, number of requesting masters (2..8).
- TIMEOUT, 1023, cycles without ack before the arbiter terminates the cycle with an error.
- IRQ_PORT, 0, master index that receives IRQ-message responses arriving while no master is granted.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- s_req  in  [NREQ] wb_cmd_request256_t  master requests.
- s_resp  out  [NREQ] wb_cmd_response256_t  per-master responses.
- m_req  out  wb_cmd_request256_t  request to the bridge.
- m_resp  in  wb_cmd_response256_t  response from the bridge.
- gnt_o  out  NREQ  one-hot current grant.
- tmo_o  out  1  one-cycle pulse on a bus timeout.

Behaviour:
- States: IDLE, BUSY, TERM.
- Reset values: state=IDLE, gnt_o=0, last=NREQ-1 (master 0 has first priority), tmo counter=0, tmo_o=0. While reset is asserted, all m_req and s_resp fields are 0.
- IDLE:
  - Searches s_req[i].cyc starting at last+1, modulo NREQ.
  - On the first hit i: gnt_o<=onehot(i), last<=i, state<=BUSY.
  - Arbitration latency is one clock: the request is seen at edge N and forwarded from cycle N+1.
  - While IDLE, m_req = 0.
- BUSY:
  - m_req = s_req[g] (combinational mux of the granted master).
  - s_resp[g] = m_resp; every other s_resp = 0.
  - The grant holds while s_req[g].cyc=1. Other masters' requests are ignored and receive no ack; they wait.
  - When s_req[g].cyc=0: state<=IDLE, gnt_o<=0, and m_req is 0 in that same cycle. The next arbitration starts in the following cycle from last+1, so fairness holds: a master with continuous requests cannot win twice while another master is waiting.
- Timeout:
  - The counter clears on entry to BUSY and on any cycle with m_resp.ack=1; otherwise it increments while BUSY.
  - When the count reaches TIMEOUT: for one cycle, s_resp[g].ack=1 and err=ERR with dat=0, the bridge is given m_req.cyc=0, tmo_o=1, state<=TERM.
  - A bridge ack arriving in the same cycle as expiry wins: it is forwarded, there is no timeout, and the counter clears.
- TERM:
  - m_req = 0; s_resp[g] = 0.
  - Waits for s_req[g].cyc=0, then goes to IDLE and clears gnt_o. Any late m_resp is discarded.
- IRQ messages:
  - Condition: m_resp.ack=1 and m_resp.err==IRQ while state=IDLE or TERM.
  - Action: forward to s_resp[IRQ_PORT] for that cycle.
  - While BUSY, an IRQ response goes to the granted master, since it is treated as that master's response.
- Simultaneous events:
  - A master dropping cyc and another raising cyc in the same cycle gives the new winner its grant two cycles later (one cycle through IDLE, then BUSY).
  - The granted master dropping cyc in the same cycle as timeout expiry is treated as normal completion: no err, tmo_o=0.
- Reset mid-cycle: the grant drops immediately, there is no err to the master, and the counter clears.
- Width rules:
  - The counter is clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
  - last wraps modulo NREQ, including non-power-of-2 NREQ.

Test Plan:
- Single master 2 reads a 4-byte register (sel=32'h000000F0, cyc held until ack): gnt_o=4'b0100 one cycle after cyc; m_req matches s_req[2]; ack with dat returns only on s_resp[2], and s_resp[0,1,3]=0.
- Masters 0, 1, 3 assert cyc together and each holds cyc for 3 cycles after grant: grant order is 0, 1, 3, then 0 again only if 0 re-requests after 3. Each gnt_o transition is separated by exactly one IDLE cycle.
- Master 1 requests and the bridge never acks, TIMEOUT=16: on the 16th BUSY cycle with no ack, s_resp[1].ack=1, err=ERR, tmo_o=1 for exactly 1 cycle; m_req.cyc=0 from then on; state stays TERM until master 1 drops cyc.
- Ack arrives on the exact expiry cycle (cycle 16): the data is forwarded with err=0, tmo_o=0, and the counter restarts.
- IDLE with m_resp.ack=1, err=IRQ, dat=32'h12345678 replicated: s_resp[IRQ_PORT=0] carries the IRQ message for one cycle; every other port is 0.
- rst_i asserted while master 2 is in BUSY: on the next edge gnt_o=0 and m_req=0. After release, master 0 wins if masters 0 and 2 both request.
